// File: rtl/legv8_control_sequencer.sv
// LEGv8 control sequencer: FETCH/DECODE/MEMWAIT/HALT FSM that drives the datapath control word and constant K.
// Define LEGV8_CONDBR_EN to add B.cond, ADDS and SUBS decode; otherwise those opcodes halt as illegal.
module legv8_control_sequencer #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [4:0]  status,
    output logic [30:0] controlWord,
    output logic [63:0] K,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_MEMWAIT = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    localparam int          B_REGW    = 8;
    localparam logic [30:0] NOP_WORD  = 31'h0000_0020;
    localparam logic        HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [2:0]  WAIT_LOAD = HAS_WAIT ? 3'(MEM_WAIT - 1) : 3'd0;

    state_t      state_q;
    logic [31:0] ir_q;
    logic [2:0]  cnt_q;
    logic        halted_q;

    logic [10:0] op11;
    logic [9:0]  op10;
    logic [7:0]  op8;
    logic [5:0]  op6;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;

    assign op11 = ir_q[31:21];
    assign op10 = ir_q[31:22];
    assign op8  = ir_q[31:24];
    assign op6  = ir_q[31:26];
    assign rd   = ir_q[4:0];
    assign rn   = ir_q[9:5];
    assign rm   = ir_q[20:16];

    logic [1:0]  dec_ps;
    logic [4:0]  dec_da;
    logic [4:0]  dec_sa;
    logic [4:0]  dec_sb;
    logic [4:0]  dec_fs;
    logic        dec_regw;
    logic        dec_ramw;
    logic        dec_en_mem;
    logic        dec_en_alu;
    logic        dec_en_b;
    logic        dec_en_pc;
    logic        dec_selb;
    logic        dec_pcsel;
    logic        dec_sl;
    logic [63:0] dec_k;
    logic        dec_legal;
    logic        dec_ldur;
    logic [30:0] dec_cw;

    logic        r_hit;
    logic [4:0]  r_fs;
    logic        r_sl;
    logic        cond_true;

    // Sign-extend first, then scale, so negative offsets keep their sign.
    logic [63:0] imm9_sx;
    logic [63:0] imm19_sx;
    logic [63:0] imm26_sx;

    assign imm9_sx  = {{55{ir_q[20]}}, ir_q[20:12]};
    assign imm19_sx = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
    assign imm26_sx = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};

`ifdef LEGV8_CONDBR_EN
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;

    logic flag_v;
    logic flag_c;
    logic flag_n;
    logic flag_z;

    assign flag_v = status[4];
    assign flag_c = status[3];
    assign flag_n = status[2];
    assign flag_z = status[1];

    always_comb begin
        cond_true = 1'b1;
        case (ir_q[3:0])
            4'h0: cond_true = flag_z;
            4'h1: cond_true = ~flag_z;
            4'h2: cond_true = flag_c;
            4'h3: cond_true = ~flag_c;
            4'h4: cond_true = flag_n;
            4'h5: cond_true = ~flag_n;
            4'h6: cond_true = flag_v;
            4'h7: cond_true = ~flag_v;
            4'h8: cond_true = flag_c & ~flag_z;
            4'h9: cond_true = ~(flag_c & ~flag_z);
            4'hA: cond_true = (flag_n == flag_v);
            4'hB: cond_true = (flag_n != flag_v);
            4'hC: cond_true = ~flag_z & (flag_n == flag_v);
            4'hD: cond_true = ~(~flag_z & (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = ^status[4:1];
    assign cond_true    = 1'b0;
`endif

    // Three-operand register ops share one decode path; only FS and SL differ.
    always_comb begin
        r_hit = 1'b0;
        r_fs  = FS_AND;
        r_sl  = 1'b0;
        case (op11)
            OP_ADD: begin r_hit = 1'b1; r_fs = FS_ADD; end
            OP_SUB: begin r_hit = 1'b1; r_fs = FS_SUB; end
            OP_AND: begin r_hit = 1'b1; r_fs = FS_AND; end
            OP_ORR: begin r_hit = 1'b1; r_fs = FS_OR;  end
            OP_EOR: begin r_hit = 1'b1; r_fs = FS_XOR; end
`ifdef LEGV8_CONDBR_EN
            OP_ADDS: begin r_hit = 1'b1; r_fs = FS_ADD; r_sl = 1'b1; end
            OP_SUBS: begin r_hit = 1'b1; r_fs = FS_SUB; r_sl = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        dec_ps     = 2'b01;
        dec_da     = 5'd0;
        dec_sa     = 5'd0;
        dec_sb     = 5'd0;
        dec_fs     = FS_AND;
        dec_regw   = 1'b0;
        dec_ramw   = 1'b0;
        dec_en_mem = 1'b0;
        dec_en_alu = 1'b1;
        dec_en_b   = 1'b0;
        dec_en_pc  = 1'b0;
        dec_selb   = 1'b0;
        dec_pcsel  = 1'b0;
        dec_sl     = 1'b0;
        dec_k      = 64'd0;
        dec_legal  = 1'b1;
        dec_ldur   = 1'b0;

        if (r_hit) begin
            dec_da   = rd;
            dec_sa   = rn;
            dec_sb   = rm;
            dec_fs   = r_fs;
            dec_regw = 1'b1;
            dec_sl   = r_sl;
        end else if (op11 == OP_LSL || op11 == OP_LSR) begin
            dec_da   = rd;
            dec_sa   = rn;
            dec_fs   = (op11 == OP_LSL) ? FS_LSL : FS_LSR;
            dec_selb = 1'b1;
            dec_regw = 1'b1;
            dec_k    = {58'd0, ir_q[15:10]};
        end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
            dec_da   = rd;
            dec_sa   = rn;
            dec_fs   = (op10 == OP_ADDI) ? FS_ADD : FS_SUB;
            dec_selb = 1'b1;
            dec_regw = 1'b1;
            dec_k    = {52'd0, ir_q[21:10]};
        end else if (op11 == OP_LDUR) begin
            dec_da     = rd;
            dec_sa     = rn;
            dec_fs     = FS_ADD;
            dec_selb   = 1'b1;
            dec_en_mem = 1'b1;
            dec_en_alu = 1'b0;
            dec_regw   = 1'b1;
            dec_k      = imm9_sx;
            dec_ldur   = 1'b1;
        end else if (op11 == OP_STUR) begin
            dec_sa     = rn;
            dec_sb     = rd;
            dec_fs     = FS_ADD;
            dec_selb   = 1'b1;
            dec_ramw   = 1'b1;
            dec_en_b   = 1'b1;
            dec_en_alu = 1'b0;
            dec_k      = imm9_sx;
        end else if (op6 == OP_B) begin
            dec_ps    = 2'b10;
            dec_pcsel = 1'b1;
            dec_k     = imm26_sx;
        end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
            // ALU ORs Rt with XZR so status[0] reflects Rt==0 in this same cycle.
            dec_ps    = 2'b10;
            dec_sa    = rd;
            dec_sb    = 5'd31;
            dec_fs    = FS_OR;
            dec_k     = imm19_sx;
            dec_pcsel = (op8 == OP_CBZ) ? status[0] : ~status[0];
`ifdef LEGV8_CONDBR_EN
        end else if (op8 == OP_BCOND) begin
            dec_ps    = 2'b10;
            dec_k     = imm19_sx;
            dec_pcsel = cond_true;
`endif
        end else begin
            dec_legal = 1'b0;
        end
    end

    assign dec_cw = {dec_ps, dec_da, dec_sa, dec_sb, dec_fs,
                     dec_regw, dec_ramw, dec_en_mem, dec_en_alu, dec_en_b,
                     dec_en_pc, dec_selb, dec_pcsel, dec_sl};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            ir_q     <= 32'd0;
            cnt_q    <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_q    <= instruction;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (dec_ldur && HAS_WAIT) begin
                        state_q <= S_MEMWAIT;
                        cnt_q   <= WAIT_LOAD;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_MEMWAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= S_FETCH;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: halted_q <= 1'b1;
            endcase
        end
    end

    // A waiting LDUR holds the memory enable but defers the write and PC step to its last cycle.
    always_comb begin
        instr_ready = (state_q == S_FETCH);
        halted      = halted_q;
        controlWord = NOP_WORD;
        K           = 64'd0;
        case (state_q)
            S_DECODE: begin
                if (dec_legal) begin
                    controlWord = dec_cw;
                    K           = dec_k;
                    if (dec_ldur && HAS_WAIT) begin
                        controlWord[B_REGW]  = 1'b0;
                        controlWord[30:29]   = 2'b00;
                    end
                end
            end
            S_MEMWAIT: begin
                controlWord = dec_cw;
                K           = dec_k;
                if (cnt_q != 3'd0) begin
                    controlWord[B_REGW] = 1'b0;
                    controlWord[30:29]  = 2'b00;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// Directed bench for legv8_control_sequencer (MEM_WAIT=2): stimulus pushes per-cycle expectations, a monitor checks them.
module tb_legv8_control_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  status;
    logic [30:0] controlWord;
    logic [63:0] K;
    logic        halted;

    legv8_control_sequencer #(.MEM_WAIT(2)) dut (
        .clock       (clk),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .status      (status),
        .controlWord (controlWord),
        .K           (K),
        .halted      (halted)
    );

    typedef struct {
        string       name;
        logic [30:0] cw;
        logic [63:0] k;
        logic        rdy;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;
    bit   drained_checked = 1'b0;

    localparam logic [30:0] NOP = 31'h0000_0020;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total = total + 1;
            if (controlWord !== mon_e.cw || K !== mon_e.k || instr_ready !== mon_e.rdy || halted !== mon_e.hlt) begin
                bad = bad + 1;
                $display("FAIL %s: got cw=%b k=%h rdy=%b halted=%b, want cw=%b k=%h rdy=%b halted=%b",
                         mon_e.name, controlWord, K, instr_ready, halted, mon_e.cw, mon_e.k, mon_e.rdy, mon_e.hlt);
            end else begin
                $display("ok   %s: cw=%b k=%h rdy=%b halted=%b", mon_e.name, controlWord, K, instr_ready, halted);
            end
        end else if (done && !drained_checked) begin
            drained_checked = 1'b1;
            total = total + 1;
            if (exp_q.size() != 0) begin
                bad = bad + 1;
                $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic [4:0] st,
                        input bit chk, input string nm, input logic [30:0] cw, input logic [63:0] k,
                        input logic rdy, input logic hlt);
        exp_t e;
        reset       = r;
        instr_valid = v;
        instruction = ins;
        status      = st;
        if (chk) begin
            e.name = nm;
            e.cw   = cw;
            e.k    = k;
            e.rdy  = rdy;
            e.hlt  = hlt;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [31:0] ins, input logic [4:0] st, input string nm,
                       input logic [30:0] cw, input logic [63:0] k, input logic rdy, input logic hlt);
        step(1'b0, v, ins, st, 1'b1, nm, cw, k, rdy, hlt);
    endtask

    localparam logic [31:0] I_ADDI  = 32'h910063E5; // ADDI X5,XZR,#24
    localparam logic [31:0] I_ADD   = 32'h8B0700A1; // ADD  X1,X5,X7
    localparam logic [31:0] I_EOR   = 32'hCA05003E; // EOR  X30,X1,X5
    localparam logic [31:0] I_SUB   = 32'hCB040062; // SUB  X2,X3,X4
    localparam logic [31:0] I_LSR   = 32'hD3401D49; // LSR  X9,X10,#7
    localparam logic [31:0] I_ADDIM = 32'h913FFC41; // ADDI X1,X2,#4095
    localparam logic [31:0] I_STUR  = 32'hF81F80C4; // STUR X4,[X6,#-8]
    localparam logic [31:0] I_LDUR  = 32'hF84000E0; // LDUR X0,[X7,#0]
    localparam logic [31:0] I_CBZ   = 32'hB4000083; // CBZ  X3,#+4
    localparam logic [31:0] I_B     = 32'h17FFFFFE; // B    #-2
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

    localparam logic [30:0] W_ADDI  = {2'b01, 5'd5, 5'd31, 5'd0, 5'b01000, 9'b100100100};
    localparam logic [30:0] W_ADD   = 31'b01_00001_00101_00111_01000_10_0100_0_0_0;
    localparam logic [30:0] W_EOR   = 31'b01_11110_00001_00101_01100_10_0100_0_0_0;
    localparam logic [30:0] W_SUB   = {2'b01, 5'd2, 5'd3, 5'd4, 5'b01001, 9'b100100000};
    localparam logic [30:0] W_LSR   = {2'b01, 5'd9, 5'd10, 5'd0, 5'b10100, 9'b100100100};
    localparam logic [30:0] W_ADDIM = {2'b01, 5'd1, 5'd2, 5'd0, 5'b01000, 9'b100100100};
    localparam logic [30:0] W_STUR  = {2'b01, 5'd0, 5'd6, 5'd4, 5'b01000, 9'b010010100};
    localparam logic [30:0] W_LDW   = {2'b00, 5'd0, 5'd7, 5'd0, 5'b01000, 9'b001000100};
    localparam logic [30:0] W_LDF   = {2'b01, 5'd0, 5'd7, 5'd0, 5'b01000, 9'b101000100};
    localparam logic [30:0] W_CBZT  = {2'b10, 5'd0, 5'd3, 5'd31, 5'b00100, 9'b000100010};
    localparam logic [30:0] W_CBZN  = {2'b10, 5'd0, 5'd3, 5'd31, 5'b00100, 9'b000100000};
    localparam logic [30:0] W_B     = {2'b10, 5'd0, 5'd0, 5'd0, 5'b00000, 9'b000100010};
    localparam logic [63:0] K_M8    = 64'hFFFF_FFFF_FFFF_FFF8;

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instruction = 32'd0; status = 5'd0;
        step(1'b1, 1'b0, 32'd0, 5'd0, 1'b0, "", NOP, 64'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, I_ADD, 5'd0, 1'b1, "reset", NOP, 64'd0, 1'b1, 1'b0);

        cyc(1'b1, I_ADDI,  5'd0, "addi_fetch", NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b1, I_BAD,   5'd0, "addi_dec",   W_ADDI,  64'd24, 1'b0, 1'b0);
        cyc(1'b1, I_ADD,   5'd0, "add_fetch",  NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b1, I_BAD,   5'd0, "add_dec",    W_ADD,   64'd0,  1'b0, 1'b0);
        cyc(1'b1, I_EOR,   5'd0, "eor_fetch",  NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "eor_dec",    W_EOR,   64'd0,  1'b0, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "idle",       NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b1, I_SUB,   5'd0, "sub_fetch",  NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "sub_dec",    W_SUB,   64'd0,  1'b0, 1'b0);
        cyc(1'b1, I_LSR,   5'd0, "lsr_fetch",  NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "lsr_dec",    W_LSR,   64'd7,  1'b0, 1'b0);
        cyc(1'b1, I_ADDIM, 5'd0, "addim_fetch", NOP,    64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "addim_dec",  W_ADDIM, 64'd4095, 1'b0, 1'b0);
        cyc(1'b1, I_STUR,  5'd0, "stur_fetch", NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "stur_dec",   W_STUR,  K_M8,   1'b0, 1'b0);

        cyc(1'b1, I_LDUR,  5'd0, "ldur_fetch", NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b1, I_BAD,   5'd0, "ldur_dec",   W_LDW,   64'd0,  1'b0, 1'b0);
        cyc(1'b1, I_BAD,   5'd0, "ldur_wait1", W_LDW,   64'd0,  1'b0, 1'b0);
        cyc(1'b1, I_BAD,   5'd0, "ldur_final", W_LDF,   64'd0,  1'b0, 1'b0);

        cyc(1'b1, I_CBZ,   5'd1, "cbz1_fetch", NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd1, "cbz_taken",  W_CBZT,  64'd16, 1'b0, 1'b0);
        cyc(1'b1, I_CBZ,   5'd0, "cbz0_fetch", NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "cbz_not",    W_CBZN,  64'd16, 1'b0, 1'b0);
        cyc(1'b1, I_B,     5'd0, "b_fetch",    NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "b_dec",      W_B,     K_M8,   1'b0, 1'b0);

        cyc(1'b1, I_LDUR,  5'd0, "ldur2_fetch", NOP,    64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "ldur2_dec",  W_LDW,   64'd0,  1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 5'd0, 1'b1, "ldur2_wait_rst", W_LDW, 64'd0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "after_rst1", NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "after_rst2", NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b1, I_ADD,   5'd0, "add2_fetch", NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "add2_dec",   W_ADD,   64'd0,  1'b0, 1'b0);

        cyc(1'b1, I_BAD,   5'd0, "bad_fetch",  NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b1, I_ADD,   5'd0, "bad_dec",    NOP,     64'd0,  1'b0, 1'b0);
        cyc(1'b1, I_ADD,   5'd0, "halt1",      NOP,     64'd0,  1'b0, 1'b1);
        cyc(1'b1, I_ADD,   5'd0, "halt2",      NOP,     64'd0,  1'b0, 1'b1);
        cyc(1'b1, I_ADD,   5'd0, "halt3",      NOP,     64'd0,  1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 5'd0, 1'b1, "halt_rst", NOP, 64'd0, 1'b0, 1'b1);
        cyc(1'b1, I_EOR,   5'd0, "rst_fetch",  NOP,     64'd0,  1'b1, 1'b0);
        cyc(1'b0, 32'd0,   5'd0, "rst_eor",    W_EOR,   64'd0,  1'b0, 1'b0);

        done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
